// File: rtl/cq_word_packer_pkg.sv
// Shared definitions for the cq byte-to-word packer: default widths, counter
// width helper and the packer state encoding used by RTL and bench utilities.
package cq_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    FILL,
    FULL_WAIT,
    FLUSH
  } pack_state_t;

  function automatic int CNT_W(input int bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

// File: rtl/cq_word_packer_if.sv
// Packed-word valid/ready bus between cq_word_packer and the wide consumer.
// word_keep exists only when PARTIAL_FLUSH_EN is defined.
interface cq_word_packer_if
  import cq_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int BYTES = BYTES_DEFAULT
);

  logic [DW*BYTES-1:0] word;
  logic                word_valid;
  logic                word_ready;
`ifdef PARTIAL_FLUSH_EN
  logic [BYTES-1:0]    word_keep;

  modport master (output word, output word_valid, output word_keep, input word_ready);
  modport slave  (input word, input word_valid, input word_keep, output word_ready);
`else
  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);
`endif

endinterface

// File: rtl/cq_word_packer_acc.sv
// Lane-addressed byte accumulator: tracks the in-flight pop (pend) and how many
// lanes of the current word are filled (cnt).
module cq_pack_acc
  import cq_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int BYTES = BYTES_DEFAULT,
  parameter int CW    = CNT_W(BYTES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                xfer,
  input  logic [DW-1:0]       dout,
  output logic [DW*BYTES-1:0] acc_word,
  output logic [CW-1:0]       cnt,
  output logic                pend
);

  logic [BYTES-1:0][DW-1:0] lanes;

  assign acc_word = lanes;

  // On a transfer the lanes are cleared so a later partial word has zero fill;
  // a byte landing at the same edge starts the next word in lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      pend <= rd;
      if (xfer) begin
        lanes <= '0;
        if (pend) begin
          lanes[0] <= dout;
          cnt      <= CW'(1);
        end else begin
          cnt <= '0;
        end
      end else if (pend) begin
        for (int i = 0; i < BYTES; i++) begin
          if (cnt == CW'(i)) lanes[i] <= dout;
        end
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cq_word_packer.sv
// Drains the byte cq and packs BYTES bytes into a little-endian word on a
// valid/ready bus. Optional partial-word flush when PARTIAL_FLUSH_EN is defined.
module cq_word_packer
  import cq_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int BYTES = BYTES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  input  logic [DW-1:0]    dout,
  output logic             rd,
`ifdef PARTIAL_FLUSH_EN
  input  logic             flush,
`endif
  cq_word_packer_if.master pack_out
);

  localparam int            CW       = CNT_W(BYTES);
  localparam logic [CW-1:0] CNT_FULL = CW'(BYTES);
  localparam logic [CW:0]   OCC_FULL = (CW+1)'(BYTES);

  pack_state_t         state, state_next;
  logic [DW*BYTES-1:0] acc_word;
  logic [CW-1:0]       acc_cnt;
  logic                acc_pend;
  logic                out_free;
  logic                full_xfer;
  logic                part_xfer;
  logic                xfer;
  logic                flush_req;
  logic                flush_busy;
  logic                room;
  logic [CW:0]         occ;

`ifdef PARTIAL_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign out_free   = !pack_out.word_valid || pack_out.word_ready;
  assign full_xfer  = (acc_cnt == CNT_FULL) && out_free;
  assign part_xfer  = (state == FLUSH) && !acc_pend && out_free;
  assign xfer       = full_xfer || part_xfer;
  assign flush_busy = flush_req || (state == FLUSH);

  // A pop requested now lands one cycle later. It is safe if a lane will be
  // free then, or if the word it completes is certain to transfer (output free
  // now and no transfer this edge), which keeps pops back-to-back at 1 byte/clk.
  always_comb begin
    occ  = (xfer ? '0 : {1'b0, acc_cnt}) + {{CW{1'b0}}, acc_pend};
    room = (occ < OCC_FULL) || ((occ == OCC_FULL) && out_free);
  end

  assign rd = reset && !empty && room && !flush_busy;

  cq_pack_acc #(
    .DW    (DW),
    .BYTES (BYTES),
    .CW    (CW)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .xfer     (xfer),
    .dout     (dout),
    .acc_word (acc_word),
    .cnt      (acc_cnt),
    .pend     (acc_pend)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  // Flush is entered only with something to emit (captured or in flight);
  // a byte still in flight is waited for in FLUSH before the partial transfer.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (acc_cnt == CNT_FULL && !out_free)
          state_next = FULL_WAIT;
        else if (flush_req && ((acc_cnt != '0 && !full_xfer) || acc_pend))
          state_next = FLUSH;
      end
      FULL_WAIT: if (out_free)  state_next = FILL;
      FLUSH:     if (part_xfer) state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack_out.word       <= '0;
      pack_out.word_valid <= 1'b0;
    end else if (xfer) begin
      pack_out.word       <= acc_word;
      pack_out.word_valid <= 1'b1;
    end else if (pack_out.word_ready) begin
      pack_out.word_valid <= 1'b0;
    end
  end

`ifdef PARTIAL_FLUSH_EN
  logic [BYTES-1:0] keep_next;

  always_comb begin
    keep_next = '0;
    for (int i = 0; i < BYTES; i++) keep_next[i] = (CW'(i) < acc_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pack_out.word_keep <= '0;
    else if (xfer) pack_out.word_keep <= keep_next;
  end
`endif

endmodule

// File: tb/tb_cq_word_packer.sv
// Directed bench for cq_word_packer with a behavioural 1-cycle-latency cq model.
// Flush sequences are included when PARTIAL_FLUSH_EN is defined.
module tb_cq_word_packer;
  import cq_pkg::*;

  localparam int DW    = 8;
  localparam int BYTES = 4;

  typedef struct {
    string       name;
    int          n_bytes;
    logic [63:0] bytes;
    int          n_words;
    logic [63:0] words;
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       empty;
  logic [7:0] dout  = 8'h00;
  logic       rd;
`ifdef PARTIAL_FLUSH_EN
  logic       flush = 1'b0;
`endif

  cq_word_packer_if #(.DW(DW), .BYTES(BYTES)) pk_if ();

  cq_word_packer #(.DW(DW), .BYTES(BYTES)) dut (
    .clk      (clk),
    .reset    (reset),
    .empty    (empty),
    .dout     (dout),
    .rd       (rd),
`ifdef PARTIAL_FLUSH_EN
    .flush    (flush),
`endif
    .pack_out (pk_if)
  );

  always #5 clk = ~clk;

  // cq model: the bench writes wr_ptr, this process owns rd_ptr
  logic [7:0] cq_mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd) begin
      dout   <= cq_mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  // Output monitor, sampled on the falling edge
  logic [31:0] got_word [64];
  logic [3:0]  got_keep [64];
  int          got_n        = 0;
  int          valid_cycles = 0;
  int          hold_viol    = 0;
  logic        prev_stall   = 1'b0;
  logic [31:0] prev_word    = '0;

  always @(negedge clk) begin
    if (pk_if.word_valid) valid_cycles <= valid_cycles + 1;
    if (pk_if.word_valid && pk_if.word_ready) begin
      got_word[got_n[5:0]] <= pk_if.word;
`ifdef PARTIAL_FLUSH_EN
      got_keep[got_n[5:0]] <= pk_if.word_keep;
`else
      got_keep[got_n[5:0]] <= 4'hF;
`endif
      got_n <= got_n + 1;
    end
    if (prev_stall && (!pk_if.word_valid || pk_if.word !== prev_word))
      hold_viol <= hold_viol + 1;
    prev_stall <= reset && pk_if.word_valid && !pk_if.word_ready;
    prev_word  <= pk_if.word;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    cq_mem[wr_ptr] = b;
    wr_ptr         = wr_ptr + 8'd1;
  endtask

  task automatic apply_stimulus(input int n, input logic [63:0] bytes);
    for (int i = 0; i < n; i++) push(bytes[8*i +: 8]);
  endtask

  function automatic logic [31:0] word_at(input int idx);
    return got_word[idx[5:0]];
  endfunction

  function automatic logic [3:0] keep_at(input int idx);
    return got_keep[idx[5:0]];
  endfunction

  vec_t vecs [4];

  initial begin
    int base;
    int vc;
    int run;
    int run_max;
    int pops;
    logic [7:0] start_rd;

    vecs[0] = '{"four_bytes",  4, 64'h00000000_0402010A, 1, 64'h00000000_0402010A};
    vecs[1] = '{"eight_seq",   8, 64'h08070605_04030201, 2, 64'h08070605_04030201};
    vecs[2] = '{"edge_values", 4, 64'h00000000_7F8000FF, 1, 64'h00000000_7F8000FF};
    vecs[3] = '{"eight_mixed", 8, 64'h88776655_44332211, 2, 64'h88776655_44332211};

    pk_if.word_ready = 1'b1;
    tick(2);
    check_output("reset_word_valid", 64'(pk_if.word_valid), 64'd0);
    check_output("reset_word",       64'(pk_if.word), 64'd0);
    check_output("reset_rd",         64'(rd), 64'd0);
    check_output("reset_cnt",        64'(dut.acc_cnt), 64'd0);
    reset = 1'b1;
    tick(2);

    // Table-driven full-word cases with the consumer always ready
    for (int v = 0; v < 4; v++) begin
      base = got_n;
      vc   = valid_cycles;
      apply_stimulus(vecs[v].n_bytes, vecs[v].bytes);
      tick(20);
      check_output({vecs[v].name, "_count"}, 64'(got_n - base), 64'(vecs[v].n_words));
      for (int w = 0; w < vecs[v].n_words; w++) begin
        check_output({vecs[v].name, "_word"}, 64'(word_at(base + w)),
                     64'(vecs[v].words[32*w +: 32]));
        check_output({vecs[v].name, "_keep"}, 64'(keep_at(base + w)), 64'hF);
      end
      check_output({vecs[v].name, "_valid_cycles"}, 64'(valid_cycles - vc),
                   64'(vecs[v].n_words));
    end

    // Back-to-back 8 bytes: rd must stay high for 8 consecutive cycles
    base    = got_n;
    run     = 0;
    run_max = 0;
    pops    = 0;
    apply_stimulus(8, 64'h08070605_04030201);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rd) begin
        run++;
        pops++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
    end
    tick(8);
    check_output("stream_rd_run",  64'(run_max), 64'd8);
    check_output("stream_rd_pops", 64'(pops), 64'd8);
    check_output("stream_count",   64'(got_n - base), 64'd2);
    check_output("stream_word0",   64'(word_at(base)), 64'h04030201);
    check_output("stream_word1",   64'(word_at(base + 1)), 64'h08070605);

    // Back-pressure: 12 bytes with consumer stalled
    base             = got_n;
    start_rd         = rd_ptr;
    pk_if.word_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'h21 + 8'(i));
    tick(20);
    check_output("bp_no_handshake", 64'(got_n - base), 64'd0);
    check_output("bp_word_valid",   64'(pk_if.word_valid), 64'd1);
    check_output("bp_word_held",    64'(pk_if.word), 64'h24232221);
    check_output("bp_pops",         64'(8'(rd_ptr - start_rd)), 64'd8);
    check_output("bp_cq_retained",  64'(8'(wr_ptr - rd_ptr)), 64'd4);
    check_output("bp_rd_low",       64'(rd), 64'd0);
    pk_if.word_ready = 1'b1;
    tick(20);
    check_output("bp_count", 64'(got_n - base), 64'd3);
    check_output("bp_word0", 64'(word_at(base)), 64'h24232221);
    check_output("bp_word1", 64'(word_at(base + 1)), 64'h28272625);
    check_output("bp_word2", 64'(word_at(base + 2)), 64'h2C2B2A29);

    // cq runs dry mid-word: partial bytes held until more arrive
    base = got_n;
    vc   = valid_cycles;
    push(8'h09);
    push(8'h06);
    tick(20);
    check_output("gap_no_valid",   64'(valid_cycles - vc), 64'd0);
    check_output("gap_word_valid", 64'(pk_if.word_valid), 64'd0);
    check_output("gap_rd_low",     64'(rd), 64'd0);
    check_output("gap_cnt",        64'(dut.acc_cnt), 64'd2);
    push(8'h05);
    push(8'h08);
    tick(20);
    check_output("gap_count", 64'(got_n - base), 64'd1);
    check_output("gap_word",  64'(word_at(base)), 64'h08050609);

    // Async reset after 3 captured bytes, then a clean word
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick(6);
    check_output("rst_pre_cnt", 64'(dut.acc_cnt), 64'd3);
    reset = 1'b0;
    #1;
    check_output("rst_word_valid", 64'(pk_if.word_valid), 64'd0);
    check_output("rst_cnt",        64'(dut.acc_cnt), 64'd0);
    check_output("rst_pend",       64'(dut.acc_pend), 64'd0);
    base = got_n;
    apply_stimulus(4, 64'h00000000_44434241);
    #1;
    check_output("rst_rd_forced_low", 64'(rd), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(20);
    check_output("rst_count", 64'(got_n - base), 64'd1);
    check_output("rst_word",  64'(word_at(base)), 64'h44434241);

`ifdef PARTIAL_FLUSH_EN
    // Partial flush of two bytes, then a flush with nothing accumulated
    base = got_n;
    push(8'h07);
    push(8'h03);
    tick(6);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    check_output("flush_count", 64'(got_n - base), 64'd1);
    check_output("flush_word",  64'(word_at(base)), 64'h00000307);
    check_output("flush_keep",  64'(keep_at(base)), 64'h3);
    base  = got_n;
    flush = 1'b1;
    tick(2);
    flush = 1'b0;
    tick(6);
    check_output("flush_empty_count", 64'(got_n - base), 64'd0);
`endif

    check_output("hold_stable", 64'(hold_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
